// File: rtl/pdp11_alu.sv
// pdp11_alu: PDP-11 style execute stage producing W/WE and holding the N/Z/V/C condition codes.
// Define ALU_ASH_EN to build the multi-cycle ASH shifter (op 15); without it op 15 is a no-op.
module pdp11_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] w,
  output logic        we,
  output logic        busy,
  output logic        n,
  output logic        z,
  output logic        v,
  output logic        c
);

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_CMP = 4'd3;
  localparam logic [3:0] OP_BIT = 4'd4;
  localparam logic [3:0] OP_BIC = 4'd5;
  localparam logic [3:0] OP_BIS = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_CLR = 4'd8;
  localparam logic [3:0] OP_COM = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;
  localparam logic [3:0] OP_NEG = 4'd12;
  localparam logic [3:0] OP_ASR = 4'd13;
  localparam logic [3:0] OP_ASL = 4'd14;
  localparam logic [3:0] OP_ASH = 4'd15;

  logic        accept;
  logic [15:0] r;
  logic        nf, zf, vf, cf;
  logic        wr, upd;
  logic [16:0] add_sum;
  logic [15:0] sub_diff, cmp_diff;

  assign add_sum  = {1'b0, b} + {1'b0, a};
  assign sub_diff = b - a;
  assign cmp_diff = a - b;

`ifdef ALU_ASH_EN
  typedef enum logic [1:0] {
    ASH_IDLE,
    ASH_SHIFT,
    ASH_DONE
  } ash_state_t;

  ash_state_t  state, state_next;
  logic [15:0] acc, acc_shifted;
  logic [5:0]  cnt, ash_count, ash_mag;
  logic        shift_right, sticky_v;
  logic        ash_load, ash_finish, bit_out, sign_flip;

  assign busy        = (state != ASH_IDLE);
  assign accept      = start && !busy;
  assign ash_count   = a[5:0];
  // Two's complement magnitude; -32 maps to 6'b100000 which still reads as 32.
  assign ash_mag     = ash_count[5] ? (~ash_count + 6'd1) : ash_count;
  assign ash_load    = accept && (op == OP_ASH) && (ash_count != 6'd0);
  assign acc_shifted = shift_right ? {acc[15], acc[15:1]} : {acc[14:0], 1'b0};
  assign bit_out     = shift_right ? acc[0] : acc[15];
  assign sign_flip   = !shift_right && (acc_shifted[15] != acc[15]);
  assign ash_finish  = (state == ASH_SHIFT) && (cnt == 6'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= ASH_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ASH_IDLE:  if (ash_load) state_next = ASH_SHIFT;
      ASH_SHIFT: if (cnt == 6'd1) state_next = ASH_DONE;
      ASH_DONE:  state_next = ASH_IDLE;
      default:   state_next = ASH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= 16'h0;
      cnt         <= 6'd0;
      shift_right <= 1'b0;
      sticky_v    <= 1'b0;
    end else if (ash_load) begin
      acc         <= b;
      cnt         <= ash_mag;
      shift_right <= ash_count[5];
      sticky_v    <= 1'b0;
    end else if (state == ASH_SHIFT) begin
      acc         <= acc_shifted;
      cnt         <= cnt - 6'd1;
      sticky_v    <= sticky_v | sign_flip;
    end
  end
`else
  assign busy   = 1'b0;
  assign accept = start;
`endif

  always_comb begin
    r   = 16'h0;
    vf  = v;
    cf  = c;
    wr  = 1'b1;
    upd = 1'b1;
    case (op)
      OP_MOV: begin r = a; vf = 1'b0; end
      OP_ADD: begin
        r  = add_sum[15:0];
        vf = (a[15] == b[15]) && (r[15] != b[15]);
        cf = add_sum[16];
      end
      OP_SUB: begin
        r  = sub_diff;
        vf = (a[15] != b[15]) && (r[15] != b[15]);
        cf = (a > b);
      end
      OP_CMP: begin
        r  = cmp_diff;
        vf = (a[15] != b[15]) && (r[15] != a[15]);
        cf = (a < b);
        wr = 1'b0;
      end
      OP_BIT: begin r = a & b;  vf = 1'b0; wr = 1'b0; end
      OP_BIC: begin r = b & ~a; vf = 1'b0; end
      OP_BIS: begin r = b | a;  vf = 1'b0; end
      OP_XOR: begin r = b ^ a;  vf = 1'b0; end
      OP_CLR: begin r = 16'h0;  vf = 1'b0; cf = 1'b0; end
      OP_COM: begin r = ~b;     vf = 1'b0; cf = 1'b1; end
      OP_INC: begin r = b + 16'd1; vf = (b == 16'h7FFF); end
      OP_DEC: begin r = b - 16'd1; vf = (b == 16'h8000); end
      OP_NEG: begin
        r  = ~b + 16'd1;
        vf = (r == 16'h8000);
        cf = (r != 16'h0);
      end
      OP_ASR: begin
        r  = {b[15], b[15:1]};
        cf = b[0];
        vf = r[15] ^ b[0];
      end
      OP_ASL: begin
        r  = {b[14:0], 1'b0};
        cf = b[15];
        vf = r[15] ^ b[15];
      end
`ifdef ALU_ASH_EN
      OP_ASH: begin
        if (ash_count == 6'd0) begin
          r  = b;
          vf = 1'b0;
          cf = 1'b0;
        end else begin
          wr  = 1'b0;
          upd = 1'b0;
        end
      end
`else
      OP_ASH: begin wr = 1'b0; upd = 1'b0; end
`endif
      default: begin wr = 1'b0; upd = 1'b0; end
    endcase
    nf = r[15];
    zf = (r == 16'h0);
  end

  // The ASH result is registered on the edge of its last shift so DONE carries we=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      w  <= 16'h0;
      we <= 1'b0;
      n  <= 1'b0;
      z  <= 1'b0;
      v  <= 1'b0;
      c  <= 1'b0;
    end else begin
      we <= 1'b0;
`ifdef ALU_ASH_EN
      if (ash_finish) begin
        w  <= acc_shifted;
        we <= 1'b1;
        n  <= acc_shifted[15];
        z  <= (acc_shifted == 16'h0);
        v  <= sticky_v | sign_flip;
        c  <= bit_out;
      end else
`endif
      if (accept) begin
        if (wr) begin
          w  <= r;
          we <= 1'b1;
        end
        if (upd) begin
          n <= nf;
          z <= zf;
          v <= vf;
          c <= cf;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdp11_alu.sv
// tb_pdp11_alu: scoreboard bench for pdp11_alu; ASH scenarios are selected by ALU_ASH_EN.
module tb_pdp11_alu;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op;
  logic [15:0] a, b, w;
  logic        we, busy, n, z, v, c;
  logic [3:0]  nzvc;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [15:0] w;
    logic        we;
    logic [3:0]  f;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_w;
  logic [3:0]  m_f;

  always #5 clk = ~clk;
  assign nzvc = {n, z, v, c};

  pdp11_alu dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .w(w), .we(we), .busy(busy), .n(n), .z(z), .v(v), .c(c)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
  endtask

  task automatic push(input string name, input logic wr, input logic [15:0] r, input logic [3:0] f);
    if (wr) m_w = r;
    m_f = f;
    exp_q.push_back('{name, m_w, wr, m_f});
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] corners [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  // Reference model: integer arithmetic for overflow/carry instead of bit-level rules.
  function automatic void model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                input logic [3:0] fin, output logic [15:0] r, output logic wr,
                                output logic [3:0] fout);
    int sx, sy, s;
    logic vv, cc;
    sx = $signed(x);
    sy = $signed(y);
    s  = 0;
    r  = 16'h0;
    wr = 1'b1;
    vv = fin[1];
    cc = fin[0];
    case (o)
      4'd0:  begin r = x; vv = 1'b0; end
      4'd1:  begin s = sy + sx; r = s[15:0]; vv = (s > 32767) || (s < -32768);
                   cc = ({16'h0, y} + {16'h0, x}) > 32'h0000FFFF; end
      4'd2:  begin s = sy - sx; r = s[15:0]; vv = (s > 32767) || (s < -32768); cc = (x > y); end
      4'd3:  begin s = sx - sy; r = s[15:0]; vv = (s > 32767) || (s < -32768); cc = (x < y); wr = 1'b0; end
      4'd4:  begin r = x & y; vv = 1'b0; wr = 1'b0; end
      4'd5:  begin r = y & ~x; vv = 1'b0; end
      4'd6:  begin r = y | x; vv = 1'b0; end
      4'd7:  begin r = y ^ x; vv = 1'b0; end
      4'd8:  begin r = 16'h0; vv = 1'b0; cc = 1'b0; end
      4'd9:  begin r = ~y; vv = 1'b0; cc = 1'b1; end
      4'd10: begin s = sy + 1; r = s[15:0]; vv = (s > 32767); end
      4'd11: begin s = sy - 1; r = s[15:0]; vv = (s < -32768); end
      4'd12: begin s = -sy; r = s[15:0]; vv = (s > 32767); cc = (y != 16'h0); end
      4'd13: begin s = sy >>> 1; r = s[15:0]; cc = y[0]; vv = r[15] ^ cc; end
      4'd14: begin s = sy * 2; r = s[15:0]; cc = y[15]; vv = r[15] ^ cc; end
`ifdef ALU_ASH_EN
      4'd15: begin r = y; vv = 1'b0; cc = 1'b0; end
`else
      4'd15: begin wr = 1'b0; fout = fin; return; end
`endif
      default: ;
    endcase
    fout = {r[15], r == 16'h0, vv, cc};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op = 4'd0; a = 16'h0; b = 16'h0;
    step();
    step();
    checks++;
    if (w !== 16'h0 || we !== 1'b0 || busy !== 1'b0 || nzvc !== 4'b0000) begin
      errors++;
      $display("FAIL reset: got w=%h we=%b busy=%b nzvc=%b want w=0000 we=0 busy=0 nzvc=0000", w, we, busy, nzvc);
    end
    reset = 1'b0;
    m_w = 16'h0;
    m_f = 4'b0000;
    step();
    checks++;
    if (we !== 1'b0 || nzvc !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got we=%b nzvc=%b want we=0 nzvc=0000", we, nzvc);
    end
  endtask

  task automatic test_add();
    exp_t e;
    push("add_ovf", 1'b1, 16'h8000, 4'b1010);
    drive(4'd1, 16'h0001, 16'h7FFF);
    step();
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (w !== e.w || we !== e.we || nzvc !== e.f) begin
      errors++;
      $display("FAIL %s: got w=%h we=%b nzvc=%b want w=%h we=%b nzvc=%b", e.name, w, we, nzvc, e.w, e.we, e.f);
    end
    step();
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL add_we_pulse: got we=%b want 0", we);
    end
  endtask

  task automatic test_cmp_bit();
    exp_t e;
    push("cmp_eq", 1'b0, 16'h0, 4'b0100);
    drive(4'd3, 16'h0005, 16'h0005);
    step();
    push("bit_zero", 1'b0, 16'h0, 4'b0100);
    drive(4'd4, 16'h00F0, 16'h000F);
    e = exp_q.pop_front();
    checks++;
    if (w !== e.w || we !== e.we || nzvc !== e.f) begin
      errors++;
      $display("FAIL %s: got w=%h we=%b nzvc=%b want w=%h we=%b nzvc=%b", e.name, w, we, nzvc, e.w, e.we, e.f);
    end
    step();
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (w !== e.w || we !== e.we || nzvc !== e.f) begin
      errors++;
      $display("FAIL %s: got w=%h we=%b nzvc=%b want w=%h we=%b nzvc=%b", e.name, w, we, nzvc, e.w, e.we, e.f);
    end
  endtask

  task automatic test_neg();
    exp_t e;
    push("neg_8000", 1'b1, 16'h8000, 4'b1011);
    drive(4'd12, 16'h1234, 16'h8000);
    step();
    push("neg_zero", 1'b1, 16'h0000, 4'b0100);
    drive(4'd12, 16'h1234, 16'h0000);
    e = exp_q.pop_front();
    checks++;
    if (w !== e.w || we !== e.we || nzvc !== e.f) begin
      errors++;
      $display("FAIL %s: got w=%h we=%b nzvc=%b want w=%h we=%b nzvc=%b", e.name, w, we, nzvc, e.w, e.we, e.f);
    end
    step();
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (w !== e.w || we !== e.we || nzvc !== e.f) begin
      errors++;
      $display("FAIL %s: got w=%h we=%b nzvc=%b want w=%h we=%b nzvc=%b", e.name, w, we, nzvc, e.w, e.we, e.f);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0]  o, f;
    logic [15:0] aa, bb, r;
    logic        wr;
    for (int i = 0; i < 80; i++) begin
      o  = 4'($urandom_range(0, 15));
      aa = pick();
      bb = pick();
      if (o == 4'd15) aa[5:0] = 6'd0;
      model(o, aa, bb, m_f, r, wr, f);
      push($sformatf("b2b_%0d_op%0d", i, o), wr, r, f);
      drive(o, aa, bb);
      step();
      e = exp_q.pop_front();
      checks++;
      if (w !== e.w || we !== e.we || nzvc !== e.f) begin
        errors++;
        $display("FAIL %s: got w=%h we=%b nzvc=%b want w=%h we=%b nzvc=%b", e.name, w, we, nzvc, e.w, e.we, e.f);
      end
    end
    start = 1'b0;
    step();
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL b2b_we_drop: got we=%b want 0", we);
    end
  endtask

`ifdef ALU_ASH_EN
  typedef struct {
    logic [15:0] a, b, w;
    logic [3:0]  f;
    int          nbusy;
  } ash_case_t;

  task automatic test_ash();
    ash_case_t cases[4];
    exp_t e;
    int   nb;
    bit   done;
    cases[0] = '{16'h0003, 16'h4001, 16'h0008, 4'b0010, 4};
    cases[1] = '{16'h003E, 16'h8003, 16'hE000, 4'b1001, 3};
    cases[2] = '{16'h0020, 16'h8000, 16'hFFFF, 4'b1001, 33};
    cases[3] = '{16'h0014, 16'h1234, 16'h0000, 4'b0110, 21};
    foreach (cases[k]) begin
      nb   = 0;
      done = 1'b0;
      push($sformatf("ash_%0d", k), 1'b1, cases[k].w, cases[k].f);
      drive(4'd15, cases[k].a, cases[k].b);
      for (int i = 0; i < 64 && !done; i++) begin
        step();
        // Hammer start with unrelated ops while busy; all must be dropped.
        if (busy === 1'b1) begin
          nb++;
          drive(4'($urandom_range(0, 14)), 16'($urandom), 16'($urandom));
        end else begin
          start = 1'b0;
        end
        if (we === 1'b1) begin
          done = 1'b1;
          e = exp_q.pop_front();
          checks++;
          if (w !== e.w || nzvc !== e.f || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s: got w=%h nzvc=%b busy=%b want w=%h nzvc=%b busy=1", e.name, w, nzvc, busy, e.w, e.f);
          end
        end
      end
      if (!done) begin
        errors++;
        checks++;
        $display("FAIL ash_%0d_timeout: no we within 64 cycles, busy=%b", k, busy);
        void'(exp_q.pop_front());
      end
      step();
      start = 1'b0;
      checks++;
      if (nb !== cases[k].nbusy || busy !== 1'b0 || we !== 1'b0 || w !== cases[k].w) begin
        errors++;
        $display("FAIL ash_%0d_after: got busy_cycles=%0d busy=%b we=%b w=%h want busy_cycles=%0d busy=0 we=0 w=%h",
                 k, nb, busy, we, w, cases[k].nbusy, cases[k].w);
      end
    end
  endtask

  task automatic test_ash_zero();
    exp_t e;
    push("ash_zero", 1'b1, 16'h8001, 4'b1000);
    drive(4'd15, 16'hFFC0, 16'h8001);
    step();
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (w !== e.w || we !== e.we || nzvc !== e.f || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got w=%h we=%b nzvc=%b busy=%b want w=%h we=%b nzvc=%b busy=0",
               e.name, w, we, nzvc, busy, e.w, e.we, e.f);
    end
  endtask

  task automatic test_ash_reset();
    int stray;
    drive(4'd15, 16'h0030, 16'h8003);
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ash_reset_pre: got busy=%b want 1", busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_w = 16'h0;
    m_f = 4'b0000;
    checks++;
    if (busy !== 1'b0 || we !== 1'b0 || w !== 16'h0 || nzvc !== 4'b0000) begin
      errors++;
      $display("FAIL ash_reset: got busy=%b we=%b w=%h nzvc=%b want busy=0 we=0 w=0000 nzvc=0000", busy, we, w, nzvc);
    end
    stray = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (we !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL ash_reset_abort: got %0d cycles with we/busy high want 0", stray);
    end
  endtask
`else
  task automatic test_ash_disabled();
    exp_t e;
    push("ash_off_setup", 1'b1, 16'hEDCB, 4'b1001);
    drive(4'd9, 16'h0000, 16'h1234);
    step();
    push("ash_off", 1'b0, 16'h0, m_f);
    drive(4'd15, 16'h0003, 16'h4001);
    e = exp_q.pop_front();
    checks++;
    if (w !== e.w || we !== e.we || nzvc !== e.f) begin
      errors++;
      $display("FAIL %s: got w=%h we=%b nzvc=%b want w=%h we=%b nzvc=%b", e.name, w, we, nzvc, e.w, e.we, e.f);
    end
    step();
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (w !== e.w || we !== e.we || nzvc !== e.f || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got w=%h we=%b nzvc=%b busy=%b want w=%h we=%b nzvc=%b busy=0",
               e.name, w, we, nzvc, busy, e.w, e.we, e.f);
    end
    step();
    checks++;
    if (we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ash_off_idle: got we=%b busy=%b want we=0 busy=0", we, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_cmp_bit();
    test_neg();
    test_back_to_back();
`ifdef ALU_ASH_EN
    test_ash();
    test_ash_zero();
    test_ash_reset();
`else
    test_ash_disabled();
`endif
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdp11_alu.md
# pdp11_alu

Execute stage directly downstream of the register file: consumes operand buses A (source, R[sela]) and B (destination, R[selb]), computes a 16-bit result, and returns it on W with a one-cycle write strobe back into R[selb]. Holds the processor condition codes N, Z, V and C. Single-cycle for all ops except ASH, which is a multi-cycle arithmetic shift with a busy handshake.

## Interface
- No parameters.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  issue op with current a/b; sampled only when busy=0.
- op  input  4  operation code (see Operation).
- a  input  16  source operand (register file bus A).
- b  input  16  destination operand (register file bus B).
- w  output  16  result to register file write bus; registered.
- we  output  1  write strobe to register file; one-cycle pulse, registered.
- busy  output  1  high while ASH in progress.
- n, z, v, c  output  1 each  condition codes; registered.

## Operation
- Op codes, result r; "keep" = flag unchanged; N=r[15], Z=(r==0) unless stated:
  - 0 MOV r=a; V=0, C keep.
  - 1 ADD r=b+a; V signed overflow, C carry-out of bit 15.
  - 2 SUB r=b-a; V signed overflow, C=1 on borrow (a>b unsigned).
  - 3 CMP r=a-b, no write; V overflow, C borrow.
  - 4 BIT r=a&b, no write; V=0, C keep.
  - 5 BIC r=b&~a; 6 BIS r=b|a; 7 XOR r=b^a; all V=0, C keep.
  - 8 CLR r=0; N=0 Z=1 V=0 C=0.
  - 9 COM r=~b; V=0, C=1.
  - 10 INC r=b+1; V=(b==16'h7FFF), C keep. 11 DEC r=b-1; V=(b==16'h8000), C keep.
  - 12 NEG r=-b; V=(r==16'h8000), C=(r!=0).
  - 13 ASR r={b[15],b[15:1]}; C=b[0], V=N^C. 14 ASL r={b[14:0],0}; C=b[15], V=N^C.
  - 15 ASH shift b by signed count a[5:0] (positive left, negative arithmetic right; range -32..+31).
- Flags written on every accepted op, including CMP/BIT.
- we asserted for one cycle after every accepted op except CMP and BIT.
- ASH FSM: IDLE -> SHIFT when start, op=15, count!=0; load acc=b, cnt=|count|, dir. Each SHIFT cycle: one bit shifted, cnt-1; C = bit shifted out; V sticky-set if acc[15] changes on any left step. cnt reaches 0 -> DONE (one cycle: w=acc, we=1, flags written, N/Z from acc) -> IDLE.
- ASH with count 0: single-cycle; r=b, C=0, V=0.
- Right shift by >=16 saturates to all sign bits; left shift by >=16 yields 0.
- start while busy=1 ignored; no queuing.

## Timing
- Reset: w=0, we=0, busy=0, n=z=v=c=0, FSM IDLE; reset mid-ASH aborts with no write.
- Single-cycle ops: start sampled at edge k; w, we, flags valid after edge k (cycle k+1); we low after edge k+1 unless new op.
- Back-to-back single-cycle ops accepted every cycle.
- ASH count |n|>0: busy high from edge k to edge k+|n|; DONE cycle has we=1 and busy=1; busy=0 and we=0 after edge k+|n|+1; next start accepted in the cycle after DONE.
- a, b need only be stable in the start cycle; ASH latches operands.

## Configuration
- ALU_ASH_EN defined: op 15 implemented as above.
- Undefined: op 15 is a no-op — no write, flags unchanged, busy held 0; no shifter/FSM logic synthesized.

## Test plan
- Reset: assert reset 2 cycles -> w=0, we=0, busy=0, nzvc=0000.
- ADD a=16'h0001 b=16'h7FFF -> w=16'h8000, we pulse 1 cycle, N=1 Z=0 V=1 C=0.
- CMP a=5 b=5 then BIT a=16'h00F0 b=16'h000F -> we stays 0; Z=1 C=0 after CMP; Z=1 and C held at 0 after BIT.
- NEG b=16'h8000 -> w=16'h8000, V=1, C=1; NEG b=0 -> w=0, Z=1, C=0.
- ASH a=16'h0003 b=16'h4001 -> busy 4 cycles, w=16'h0008 in DONE, V=1 (sign changed), C=0; start pulses during busy ignored.
- ASH a=6'h3E (-2) b=16'h8003 -> w=16'hE000, C=1; reset asserted mid-shift -> no we, busy=0 next cycle.
